prog_imem: RTL and testbench

PROG_IMEM -- requirements
Module: prog_imem

---
 rtl/prog_imem_if.sv | 28 ++
 rtl/prog_imem.sv | 108 ++++++++++
 tb/tb_prog_imem.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/prog_imem_if.sv
// Fetch and program-load bus for prog_imem.
// The master side drives addresses and load bytes; the slave side is the memory.
interface prog_imem_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] Read_Address;
    logic              fetch_en;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              addr_err;
    logic              load_start;
    logic              load_valid;
    logic              load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;

    modport master (
        output Read_Address, fetch_en, load_start, load_valid, load_last, load_data,
        input  instruction, instr_valid, addr_err, load_ready, load_done
    );

    modport slave (
        input  Read_Address, fetch_en, load_start, load_valid, load_last, load_data,
        output instruction, instr_valid, addr_err, load_ready, load_done
    );
endinterface

// File: rtl/prog_imem.sv
// Program instruction memory with a registered fetch port and a byte-serial loader.
// Optional feature: define PROG_IMEM_BOOT_PROG_EN to preload a six-word boot program
// on reset; otherwise reset clears the whole memory.
module prog_imem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input logic         clk,
    input logic         reset,
    prog_imem_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    localparam logic StRun  = 1'b0;
    localparam logic StLoad = 1'b1;

    logic              state_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic              err_q;
    logic              done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              out_of_range;
    logic              load_end;

`ifdef PROG_IMEM_BOOT_PROG_EN
    function automatic logic [DATA_W-1:0] boot_word(input int unsigned idx);
        case (idx)
            0:       boot_word = DATA_W'(8'h49);
            1:       boot_word = DATA_W'(8'hC1);
            2:       boot_word = DATA_W'(8'h18);
            3:       boot_word = DATA_W'(8'hA9);
            4:       boot_word = DATA_W'(8'h7D);
            5:       boot_word = DATA_W'(8'h1C);
            default: boot_word = '0;
        endcase
    endfunction
`endif

    // Decode fetch range and end-of-load conditions.
    always_comb begin
        out_of_range = ({1'b0, bus.Read_Address} >= DEPTH_EXT);
        load_end     = bus.load_valid && (bus.load_last || (wptr_q == LAST_PTR));
    end

    // State, fetch pipeline and memory writes; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            wptr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef PROG_IMEM_BOOT_PROG_EN
                mem_q[i] <= boot_word(i);
`else
                mem_q[i] <= '0;
`endif
            end
        end else begin
            done_q <= 1'b0;
            if (state_q == StRun) begin
                // A fetch issued alongside load_start still updates the data, but valid
                // must be low once the state register reads LOAD.
                valid_q <= bus.fetch_en && !bus.load_start;
                if (bus.fetch_en) begin
                    if (out_of_range) begin
                        instr_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        instr_q <= mem_q[bus.Read_Address[PTR_W-1:0]];
                        err_q   <= 1'b0;
                    end
                end
                if (bus.load_start) begin
                    state_q <= StLoad;
                    wptr_q  <= '0;
                end
            end else begin
                valid_q <= 1'b0;
                if (bus.load_valid) begin
                    mem_q[wptr_q] <= bus.load_data;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (load_end) begin
                    state_q <= StRun;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    // Drive the bus outputs from the registered state.
    always_comb begin
        bus.instruction = instr_q;
        bus.instr_valid = valid_q;
        bus.addr_err    = err_q;
        bus.load_ready  = (state_q == StLoad);
        bus.load_done   = done_q;
    end
endmodule

// File: tb/tb_prog_imem.sv
// Self-checking bench for prog_imem: directed scenarios followed by random traffic,
// all compared against a behavioural memory model.
module tb_prog_imem;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_imem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    prog_imem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [7:0] m_mem [DEPTH];
    bit         m_load;
    int         m_wptr;
    logic [7:0] m_instr;
    logic       m_valid;
    logic       m_err;
    logic       m_done;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
`ifdef PROG_IMEM_BOOT_PROG_EN
        m_mem[0] = 8'h49; m_mem[1] = 8'hC1; m_mem[2] = 8'h18;
        m_mem[3] = 8'hA9; m_mem[4] = 8'h7D; m_mem[5] = 8'h1C;
`endif
        m_load  = 1'b0;
        m_wptr  = 0;
        m_instr = 8'h00;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_done  = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check every output.
    task automatic cycle(input logic r, input int addr, input logic fe, input logic ls,
                         input logic lv, input logic ll, input logic [7:0] ld);
        rst              = r;
        bus.Read_Address = addr[ADDR_W-1:0];
        bus.fetch_en     = fe;
        bus.load_start   = ls;
        bus.load_valid   = lv;
        bus.load_last    = ll;
        bus.load_data    = ld;
        if (r) begin
            model_reset();
        end else if (!m_load) begin
            m_done  = 1'b0;
            m_valid = fe && !ls;
            if (fe) begin
                if (addr >= DEPTH) begin
                    m_instr = 8'h00;
                    m_err   = 1'b1;
                end else begin
                    m_instr = m_mem[addr];
                    m_err   = 1'b0;
                end
            end
            if (ls) begin
                m_load = 1'b1;
                m_wptr = 0;
            end
        end else begin
            m_done  = 1'b0;
            m_valid = 1'b0;
            if (lv) begin
                bit fin;
                fin = ll || (m_wptr == DEPTH - 1);
                m_mem[m_wptr] = ld;
                m_wptr++;
                if (fin) begin
                    m_load = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("instruction", 32'(bus.instruction), 32'(m_instr));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("addr_err",    32'(bus.addr_err),    32'(m_err));
        chk("load_ready",  32'(bus.load_ready),  32'(m_load));
        chk("load_done",   32'(bus.load_done),   32'(m_done));
    endtask

    task automatic fetch(input int addr);
        cycle(1'b0, addr, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, last, d);
    endtask

    initial begin
        // Reset with noisy inputs: reset must win.
        cycle(1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset image fetched back-to-back, then idle hold.
        for (int a = 0; a < 6; a++) fetch(a);
        fetch(3);
        idle();
        idle();

        // Out-of-range fetch then recovery, and the boundary addresses.
        fetch(40);
        idle();
        fetch(1);
        fetch(DEPTH);
        fetch(DEPTH - 1);

        // Full-depth load without load_last; the fetch follows load_done directly.
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            load_byte(8'($urandom), 1'b0);
            // load_start and fetch_en inside LOAD must be ignored
            if (i == 10) cycle(1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        fetch(DEPTH - 1);
        fetch(0);

        // Short load with a gap; load_last without load_valid does nothing.
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        load_byte(8'h11, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        load_byte(8'h22, 1'b0);
        idle();
        load_byte(8'h33, 1'b1);
        for (int a = 0; a < 4; a++) fetch(a);

        // load_start with a same-cycle fetch: data serviced, valid suppressed.
        cycle(1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        load_byte(8'h5A, 1'b0);
        load_byte(8'hA5, 1'b0);
        // Abandon the load with reset; memory returns to the reset image.
        cycle(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        for (int a = 0; a < DEPTH; a++) fetch(a);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic r;
            r = ($urandom_range(0, 149) == 0);
            if (!m_load)
                cycle(r, $urandom_range(0, 45), 1'($urandom), ($urandom_range(0, 19) == 0),
                      1'($urandom), 1'($urandom), 8'($urandom));
            else
                cycle(r, $urandom_range(0, 45), 1'($urandom), 1'($urandom),
                      1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
